// File: rtl/buf_loader_if.sv
// buf_loader_if: load handshake, serial buffer link and status signals of buf_loader
interface buf_loader_if;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic [2:0] load_addr;
  logic       abort;
  logic       sclk;
  logic       sin;
  logic       ssel;
  logic [2:0] saddr;
  logic       sout;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       frame_done;
  logic       frame_err;
  logic       busy;
  modport slave (
    input  load_valid, load_data, load_addr, abort, sout,
    output load_ready, sclk, sin, ssel, saddr, rd_valid, rd_data, frame_done, frame_err, busy
  );
  modport master (
    output load_valid, load_data, load_addr, abort, sout,
    input  load_ready, sclk, sin, ssel, saddr, rd_valid, rd_data, frame_done, frame_err, busy
  );
endinterface

// File: rtl/buf_loader.sv
// buf_loader: shifts loaded bytes MSB first into a serial pattern buffer while reading back its old contents
module buf_loader #(
  parameter int HALF        = 1,
  parameter int FRAME_BYTES = 32
) (
  input logic       clk,
  input logic       rst,
  buf_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, END} state_t;
  state_t     state_q, state_d;
  logic [3:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, rd_data_q, rd_data_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] saddr_q, saddr_d;
  logic       sclk_q, sclk_d, sin_q, sin_d, ssel_q, ssel_d;
  logic       rd_valid_q, rd_valid_d, done_q, done_d, err_q, err_d;
  logic       ph_end, last;
  assign bus.load_ready = !rst && (state_q == IDLE || state_q == WAIT);
  assign ph_end         = ph_q == 4'(HALF - 1);
  assign last           = cnt_q == 5'(FRAME_BYTES - 1);
  assign bus.sclk       = sclk_q;
  assign bus.sin        = sin_q;
  assign bus.ssel       = ssel_q;
  assign bus.busy       = ssel_q;
  assign bus.saddr      = saddr_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  // next state: abort beats a transfer, a transfer restarts the bit engine, otherwise advance the phases
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    cnt_d      = cnt_q;
    saddr_d    = saddr_q;
    sclk_d     = sclk_q;
    sin_d      = sin_q;
    ssel_d     = ssel_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      sclk_d  = 1'b0;
      ssel_d  = 1'b0;
      err_d   = 1'b1;
    end else if (bus.load_valid && bus.load_ready) begin
      state_d = LO;
      tx_d    = bus.load_data;
      sin_d   = bus.load_data[7];
      ph_d    = '0;
      bit_d   = 3'd7;
      sclk_d  = 1'b0;
      if (state_q == IDLE) begin
        saddr_d = bus.load_addr;
        cnt_d   = '0;
        ssel_d  = 1'b1;
      end
    end else begin
      case (state_q)
        LO: begin
          ph_d = ph_end ? '0 : ph_q + 4'd1;
          if (ph_end) begin
            rx_d    = {rx_q[6:0], bus.sout};
            state_d = HI;
            sclk_d  = 1'b1;
          end
        end
        HI: begin
          ph_d = ph_end ? '0 : ph_q + 4'd1;
          if (ph_end) begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
              rd_valid_d = 1'b1;
              rd_data_d  = rx_q;
              cnt_d      = last ? '0 : cnt_q + 5'd1;
              state_d    = last ? END : WAIT;
              ssel_d     = !last;
              done_d     = last;
            end else begin
              bit_d   = bit_q - 3'd1;
              tx_d    = {tx_q[6:0], 1'b0};
              sin_d   = tx_q[6];
              state_d = LO;
            end
          end
        end
        END:     state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  // state and output registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      saddr_q    <= '0;
      sclk_q     <= 1'b0;
      sin_q      <= 1'b0;
      ssel_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
      saddr_q    <= saddr_d;
      sclk_q     <= sclk_d;
      sin_q      <= sin_d;
      ssel_q     <= ssel_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_buf_loader.sv
// tb_buf_loader: directed frames with random data against a bit-queue model of the pattern buffer
module tb_buf_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  buf_loader_if b0();
  buf_loader_if b1();
  buf_loader #(.HALF(1), .FRAME_BYTES(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
  buf_loader #(.HALF(3), .FRAME_BYTES(4))  u1 (.clk(clk), .rst(rst), .bus(b1));
  int tests = 0, fails = 0;
  logic [7:0]   pre [32];
  logic [255:0] env;
  assign b0.sout = env[255];
  assign b1.sout = 1'b1;
  // pattern buffer: shifts sin in and its MSB out on every sclk rise
  initial begin
    for (int i = 0; i < 32; i++) pre[i] = (i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'($urandom);
    for (int i = 0; i < 32; i++) env[255 - 8*i -: 8] = pre[i];
    forever begin
      @(posedge b0.sclk);
      env = {env[254:0], b0.sin};
    end
  end
  int edges = 0, done_cnt = 0, err_cnt = 0, ssel_falls = 0, addr_bad = 0;
  logic sclk_p = 1'b0, ssel_p = 1'b0;
  logic [2:0] exp_addr = '0;
  logic [7:0] rd_q [$];
  bit         sin_log [$];
  // observe u0 outputs mid-cycle
  always @(negedge clk) begin
    if (b0.rd_valid) rd_q.push_back(b0.rd_data);
    if (b0.frame_done) done_cnt++;
    if (b0.frame_err) err_cnt++;
    if (b0.sclk !== sclk_p) begin
      edges++;
      if (b0.sclk) sin_log.push_back(b0.sin);
    end
    if (b0.ssel && b0.saddr !== exp_addr) addr_bad++;
    if (!b0.ssel && ssel_p) ssel_falls++;
    sclk_p = b0.sclk;
    ssel_p = b0.ssel;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  bit         ref_bits [$];
  logic [7:0] exp_q [$];
  int         rd_i = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // n sclk rises: the buffer hands out its oldest n bits and takes the top n bits of d
  task automatic ref_shift(input logic [7:0] d, input int n, output logic [7:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got = {got[6:0], ref_bits.pop_front()};
      ref_bits.push_back(d[7-i]);
    end
  endtask
  task automatic send0(input logic [7:0] d, input logic [2:0] a, input bit full);
    int n;
    logic [7:0] got;
    @(negedge clk);
    b0.load_valid = 1'b1;
    b0.load_data  = d;
    b0.load_addr  = a;
    n = 0;
    while (!b0.load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", n, 0);
    @(posedge clk);
    #1;
    b0.load_valid = 1'b0;
    if (full) begin
      ref_shift(d, 8, got);
      exp_q.push_back(got);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_rd();
    chk("rd_count", rd_q.size(), exp_q.size());
    for (int i = rd_i; i < exp_q.size() && i < rd_q.size(); i++) chk($sformatf("rd_data[%0d]", i), rd_q[i], exp_q[i]);
    rd_i = exp_q.size();
  endtask
  initial begin
    logic [7:0] d, got, rdv;
    logic [2:0] a;
    int first, run, runs, bad_run, wait_bad, sin_bad, e;
    rst = 1'b1;
    b0.load_valid = 0; b0.load_data = 0; b0.load_addr = 0; b0.abort = 0;
    b1.load_valid = 0; b1.load_data = 0; b1.load_addr = 0; b1.abort = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_u0", {b0.sclk, b0.sin, b0.ssel, b0.saddr, b0.rd_valid, b0.rd_data, b0.frame_done, b0.frame_err, b0.busy, b0.load_ready}, 0);
    chk("rst_out_u1", {b1.sclk, b1.sin, b1.ssel, b1.saddr, b1.rd_valid, b1.rd_data, b1.frame_done, b1.frame_err, b1.busy, b1.load_ready}, 0);
    rst = 1'b0;
    idle(1);
    chk("ready_after_rst", b0.load_ready, 1);
    for (int i = 0; i < 32; i++) for (int b = 7; b >= 0; b--) ref_bits.push_back(pre[i][b]);
    // HALF=3: one byte, then 20 idle cycles in WAIT
    @(negedge clk);
    b1.load_valid = 1'b1;
    b1.load_data  = 8'($urandom);
    b1.load_addr  = 3'd4;
    @(posedge clk);
    #1;
    b1.load_valid = 1'b0;
    first = -1; run = 0; runs = 0; bad_run = 0; wait_bad = 0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      if (b1.rd_valid && first < 0) begin
        first = c;
        rdv = b1.rd_data;
      end
      if (b1.sclk) run++;
      else if (run != 0) begin
        runs++;
        if (run != 3) bad_run++;
        run = 0;
      end
      if (c >= 49 && c <= 68 && !(b1.ssel && b1.busy && !b1.sclk && b1.load_ready)) wait_bad++;
    end
    chk("h3_rd_cycle", first, 48);
    chk("h3_rd_data", rdv, 8'hFF);
    chk("h3_bit_count", runs, 8);
    chk("h3_high_len", bad_run, 0);
    chk("h3_wait_hold", wait_bad, 0);
    // frame 1: addr 5, bytes 0x00..0x1F back to back
    exp_addr = 3'd5;
    for (int i = 0; i < 32; i++) send0(8'(i), 3'd5, 1);
    idle(20);
    chk("f1_sclk_edges", edges, 512);
    chk("f1_done", done_cnt, 1);
    chk("f1_first_rd", rd_q.size() > 1 ? {rd_q[0], rd_q[1]} : 16'h0, 16'hA53C);
    chk("f1_ssel_falls", ssel_falls, 1);
    chk("f1_saddr", addr_bad, 0);
    sin_bad = (sin_log.size() == 256) ? 0 : 1;
    for (int i = 0; i < 256 && i < sin_log.size(); i++) if (sin_log[i] !== 1'((i / 8) >> (7 - i % 8))) sin_bad++;
    chk("f1_sin_stream", sin_bad, 0);
    got = '0;
    for (int i = 8; i < 16 && i < sin_log.size(); i++) got = {got[6:0], sin_log[i]};
    chk("f1_sin_0x01", got, 8'h01);
    chk_rd();
    // frame 2: addr 6, load_addr 2 on byte 3, readback must equal frame 1
    exp_addr = 3'd6;
    for (int i = 0; i < 32; i++) send0(8'($urandom), (i == 0) ? 3'd6 : (i == 3) ? 3'd2 : 3'($urandom), 1);
    idle(20);
    chk("f2_done", done_cnt, 2);
    chk("f2_saddr", addr_bad, 0);
    e = 0;
    for (int i = 0; i < 32; i++) if (rd_q.size() < 64 || rd_q[32+i] !== 8'(i)) e++;
    chk("f2_readback", e, 0);
    chk_rd();
    // frame 3: abort in the HI phase of bit 4 of byte 7
    a = 3'($urandom);
    exp_addr = a;
    for (int i = 0; i < 7; i++) send0(8'($urandom), a, 1);
    d = 8'($urandom);
    send0(d, a, 0);
    repeat (7) @(posedge clk);
    #1;
    b0.abort = 1'b1;
    idle(1);
    b0.abort = 1'b0;
    chk("abort_ssel_err", {b0.ssel, b0.busy, b0.frame_err, b0.sclk}, 4'b0010);
    ref_shift(d, 4, got);
    idle(20);
    chk("abort_err_cnt", err_cnt, 1);
    chk("abort_no_done", done_cnt, 2);
    chk_rd();
    // frame 4: byte counter restarts at 0, so done only on byte 32
    a = 3'($urandom);
    exp_addr = a;
    for (int i = 0; i < 31; i++) send0(8'($urandom), a, 1);
    idle(20);
    chk("f4_no_early_done", done_cnt, 2);
    send0(8'($urandom), a, 1);
    idle(20);
    chk("f4_done", done_cnt, 3);
    chk("f4_saddr", addr_bad, 0);
    chk_rd();
    // reset mid-byte: three sclk rises reach the buffer before the edge that resets
    a = 3'($urandom);
    exp_addr = a;
    d = 8'($urandom);
    send0(d, a, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    chk("midrst_out", {b0.sclk, b0.sin, b0.ssel, b0.saddr, b0.rd_valid, b0.rd_data, b0.frame_done, b0.frame_err, b0.busy, b0.load_ready}, 0);
    rst = 1'b0;
    ref_shift(d, 3, got);
    idle(1);
    chk("midrst_ready", b0.load_ready, 1);
    chk("midrst_no_pulse", {done_cnt[7:0], err_cnt[7:0]}, {8'd3, 8'd1});
    // abort with load_valid in IDLE: transfer happens, abort ignored
    a = 3'($urandom);
    exp_addr = a;
    b0.abort = 1'b1;
    send0(8'($urandom), a, 1);
    b0.abort = 1'b0;
    chk("idle_abort_ssel", b0.ssel, 1);
    idle(18);
    chk("idle_abort_no_err", err_cnt, 1);
    chk_rd();
    // abort with load_valid in WAIT: abort wins, no new byte
    e = edges;
    @(negedge clk);
    b0.abort      = 1'b1;
    b0.load_valid = 1'b1;
    b0.load_data  = 8'($urandom);
    idle(1);
    b0.abort      = 1'b0;
    b0.load_valid = 1'b0;
    chk("wait_abort_out", {b0.ssel, b0.frame_err, b0.load_ready}, 3'b011);
    idle(10);
    chk("wait_abort_no_sclk", edges, e);
    chk("wait_abort_err_cnt", err_cnt, 2);
    chk_rd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
